// File: rtl/muldiv_seq.sv
// muldiv_seq - iterative RV32M multiply/divide sequencer for the EX stage.
//
// Takes one M-extension op at a time and spends one cycle per operand bit.
// Multiplies use shift-add and divides use restoring division. While it
// iterates it asks the pipeline to stall. It then presents the result for
// exactly one cycle, alongside done_o.
//
// Ports:
//   clk       core clock, rising edge
//   rst_n     asynchronous reset, active low
//   start_i   EX-stage instruction is a valid M-op
//   funct3_i  000 mul, 001 mulh, 010 mulhsu, 011 mulhu,
//             100 div, 101 divu, 110 rem, 111 remu
//   a_i       rs1 operand (after forwarding)
//   b_i       rs2 operand (after forwarding)
//   flush_i   EX flush; aborts the operation in progress
//   stall_o   freeze PC/IF/ID/EX registers
//   done_o    result valid this cycle
//   result_o  result, meaningful only while done_o=1
module muldiv_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST    = CW'(W - 1);
  localparam logic [W-1:0]  MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state;
  logic [CW-1:0]  count;
  logic [2:0]     op;
  logic           neg;
  logic [2*W-1:0] acc;
  logic [W-1:0]   opb;

  logic           a_signed, b_signed, a_neg, b_neg;
  logic           div_zero, overflow, neg_in, accept;
  logic [W-1:0]   a_mag, b_mag, fast_result;

  logic [W:0]     sum, trial;
  logic [W+1:0]   diff;
  logic [2*W-1:0] acc_nxt, prod;
  logic [W-1:0]   sel, calc_result;

  // Decode the incoming op.
  // neg_in tells the fix-up stage whether the magnitude result must be negated.
  // For rem only the sign of the dividend matters.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3_i)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'b010:  a_signed = 1'b1;
      default: ;
    endcase

    a_neg = a_signed & a_i[W-1];
    b_neg = b_signed & b_i[W-1];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;

    div_zero = funct3_i[2] & (b_i == '0);
    overflow = funct3_i[2] & ~funct3_i[0] & (a_i == MIN_NEG) & (b_i == '1);

    case (funct3_i)
      3'b110:                 neg_in = a_neg;
      3'b011, 3'b101, 3'b111: neg_in = 1'b0;
      default:                neg_in = a_neg ^ b_neg;
    endcase

    if (div_zero)
      fast_result = funct3_i[1] ? a_i : '1;
    else
      fast_result = funct3_i[1] ? '0 : MIN_NEG;

    accept = (state == IDLE) & start_i & ~flush_i;
  end

  assign stall_o = accept | (state == CALC);

  // One iteration step, shared by both op classes through the acc register.
  // Multiply: acc = {partial product high, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, dividend bits shifting into quotient}.
  // The trial subtraction carries two extra bits because the shifted remainder
  // can reach 2*divisor-1, which needs W+1 bits. The top bit is then a clean borrow.
  always_comb begin
    sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : '0);
    trial = acc[2*W-1:W-1];
    diff  = {1'b0, trial} - {2'b00, opb};

    if (!op[2])
      acc_nxt = {sum, acc[W-1:1]};
    else if (!diff[W+1])
      acc_nxt = {diff[W-1:0], acc[W-2:0], 1'b1};
    else
      acc_nxt = {trial[W-1:0], acc[W-2:0], 1'b0};

    prod = neg ? -acc_nxt : acc_nxt;
    sel  = op[1] ? acc_nxt[2*W-1:W] : acc_nxt[W-1:0];

    if (!op[2])
      calc_result = (op[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
    else
      calc_result = neg ? -sel : sel;
  end

  // Control FSM.
  // done_o is registered and is high only in DONE.
  // Results are captured on the transition into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      op       <= '0;
      neg      <= 1'b0;
      acc      <= '0;
      opb      <= '0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op    <= funct3_i;
            neg   <= neg_in;
            opb   <= b_mag;
            acc   <= {{W{1'b0}}, a_mag};
            count <= '0;
            if (div_zero || overflow) begin
              result_o <= fast_result;
              done_o   <= 1'b1;
              state    <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush_i) begin
            state <= IDLE;
            count <= '0;
          end else begin
            acc   <= acc_nxt;
            count <= count + 1'b1;
            if (count == LAST) begin
              result_o <= calc_result;
              done_o   <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          count <= '0;
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq - self-checking bench for muldiv_seq.
//
// A transaction-level reference model computes each op's result with plain
// integer arithmetic, plus its latency (1 or 33 cycles). The model drives a
// per-cycle compare of stall_o/done_o/result_o. Directed ops also carry
// hand-computed literal results and latencies.
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_count = 0;
  int last_done_cyc = 0;
  logic [31:0] last_res = '0;

  bit          pend = 1'b0;
  int          done_at = 0;
  logic [31:0] exp_res = '0;

  muldiv_seq #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RV32M semantics computed with 64-bit integer arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
    longint      sa, sb, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb;
        return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    if (f[2] && (b == 0)) return 1;
    if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: tracks the one op in flight and its completion cycle.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else if (pend) begin
        if (cyc == done_at || flush_i) pend = 1'b0;
      end else if (start_i && !flush_i) begin
        pend    = 1'b1;
        done_at = cyc + refLatency(funct3_i, a_i, b_i);
        exp_res = refModel(funct3_i, a_i, b_i);
      end
      cyc++;
    end
  end

  // Per-cycle compare against the model, sampled mid-cycle.
  initial begin
    bit exp_stall, exp_done;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checkOutput("reset_stall", 32'(stall_o), 32'd0);
        checkOutput("reset_done", 32'(done_o), 32'd0);
        checkOutput("reset_result", result_o, 32'd0);
      end else begin
        exp_stall = pend ? (cyc < done_at) : (start_i & ~flush_i);
        exp_done  = pend && (cyc == done_at);
        checkOutput("stall", 32'(stall_o), 32'(exp_stall));
        checkOutput("done", 32'(done_o), 32'(exp_done));
        if (exp_done) checkOutput("model_result", result_o, exp_res);
      end
      if (done_o) begin
        done_count++;
        last_res      = result_o;
        last_done_cyc = cyc;
      end
    end
  end

  // Issue one op for a single cycle, scramble the operands afterwards, and
  // wait (bounded) for its done strobe.
  task automatic applyStimulus(input string name, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] lit_res,
                               input int lit_lat);
    int c0, acc_cyc;
    c0       = done_count;
    acc_cyc  = cyc;
    start_i  = 1'b1;
    funct3_i = f;
    a_i      = a;
    b_i      = b;
    @(posedge clk); #1;
    start_i  = 1'b0;
    a_i      = $urandom;
    b_i      = $urandom;
    funct3_i = 3'($urandom);
    for (int i = 0; i < 40 && done_count == c0; i++) begin
      @(posedge clk); #1;
    end
    checkOutput({name, "_done_count"}, 32'(done_count - c0), 32'd1);
    if (done_count != c0) begin
      checkOutput({name, "_result"}, last_res, lit_res);
      checkOutput({name, "_latency"}, 32'(last_done_cyc - acc_cyc), 32'(lit_lat));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    rst_n    = 1'b0;
    start_i  = 1'b0;
    flush_i  = 1'b0;
    funct3_i = '0;
    a_i      = '0;
    b_i      = '0;
    @(negedge clk);
    checkOutput("init_stall", 32'(stall_o), 32'd0);
    checkOutput("init_done", 32'(done_o), 32'd0);
    checkOutput("init_result", result_o, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    applyStimulus("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
    applyStimulus("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    applyStimulus("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    applyStimulus("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
    applyStimulus("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
    applyStimulus("divu",   3'd5, 32'd100,        32'd7,         32'd14,        33);
    applyStimulus("remu",   3'd7, 32'd100,        32'd7,         32'd2,         33);
    applyStimulus("divu0",  3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    applyStimulus("remu0",  3'd7, 32'd5,          32'd0,         32'd5,         1);
    applyStimulus("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    applyStimulus("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
    applyStimulus("div0s",  3'd4, 32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFFF, 1);
    applyStimulus("mulneg", 3'd0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         33);

    // Flush in cycle 10 of a mul: no done, stall low from cycle 11.
    c0       = done_count;
    start_i  = 1'b1;
    funct3_i = 3'd0;
    a_i      = 32'd7;
    b_i      = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    checkOutput("flush_stall_low", 32'(stall_o), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("flush_no_done", 32'(done_count - c0), 32'd0);
    applyStimulus("divu_after_flush", 3'd5, 32'd1000, 32'd33, 32'd30, 33);

    // Start together with flush in IDLE is not accepted.
    c0       = done_count;
    start_i  = 1'b1;
    flush_i  = 1'b1;
    funct3_i = 3'd5;
    a_i      = 32'd9;
    b_i      = 32'd2;
    @(negedge clk);
    checkOutput("start_flush_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("start_flush_no_done", 32'(done_count - c0), 32'd0);

    // Reset dropped in cycle 15 of a div.
    c0       = done_count;
    start_i  = 1'b1;
    funct3_i = 3'd4;
    a_i      = 32'hFFFF_FFF9;
    b_i      = 32'd2;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_stall", 32'(stall_o), 32'd0);
    checkOutput("midreset_done", 32'(done_o), 32'd0);
    checkOutput("midreset_result", result_o, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("midreset_no_done", 32'(done_count - c0), 32'd0);

    // mulhu with start_i held through CALC and DONE: accepted once only.
    c0       = done_count;
    start_i  = 1'b1;
    funct3_i = 3'd3;
    a_i      = 32'hFFFF_FFFF;
    b_i      = 32'hFFFF_FFFF;
    for (int i = 0; i < 40 && done_count == c0; i++) begin
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    checkOutput("held_done_count", 32'(done_count - c0), 32'd1);
    checkOutput("held_result", last_res, 32'hFFFF_FFFE);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("held_single_op", 32'(done_count - c0), 32'd1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
